// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the RV32I pipeline front end.
//   NOP_INST      bubble encoding (addi x0,x0,0)
//   if_state_e    instruction-fetch FSM states
//   if_id_t       IF/ID pipeline register contents
//   IF_ID_BUBBLE  IF/ID contents when no real instruction is held
//   word_align()  clears the byte-offset bits of an address
package rv_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_BOOT  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2,
      IF_DRAIN = 2'd3
   } if_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   i_clk, i_rst_n  clock, asynchronous active-low reset (resets to a bubble)
//   i_load          capture i_d at the next edge
//   i_stall         freeze the current contents (overrides i_load)
//   i_flush         replace contents with a bubble (overrides stall and load)
//   i_d / o_q       next / current IF/ID contents
module if_id_reg
   import rv_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_load,
   input  logic   i_stall,
   input  logic   i_flush,
   input  if_id_t i_d,
   output if_id_t o_q
);

   // NOTE: clocked state is written with non-blocking assignments so every
   // register samples its inputs from the same pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_q <= IF_ID_BUBBLE;
      end else if (i_flush) begin
         o_q <= IF_ID_BUBBLE;
      end else if (i_load && !i_stall) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the RV32I pipeline.
//   RESET_PC                first fetch address after reset
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_stall                 hazard-unit stall: hold IF/ID contents
//   i_redirect/_pc          EX-stage control transfer and its target
//   o_imem_req/_addr        instruction-memory request and word address
//   i_imem_ack/_rdata       memory acknowledge and fetched word
//   o_id_inst/_pc/_pc4      IF/ID instruction, PC and PC+4
//   o_id_valid              IF/ID holds a real instruction
module if_stage
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_id_inst,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_pc4,
   output logic        o_id_valid
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] pc_plus4, redirect_tgt;
   logic        id_load, id_flush;
   if_id_t      id_d, id_q;

   assign pc_plus4     = pc_q + 32'd4;
   assign redirect_tgt = word_align(i_redirect_pc);

   // In DRAIN the PC still points at the wrong-path request, so the address
   // stays stable until that transaction completes.
   assign o_imem_req  = (state_q == IF_FETCH) || (state_q == IF_DRAIN);
   assign o_imem_addr = pc_q;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      target_d    = target_q;
      id_load     = 1'b0;
      id_flush    = 1'b0;
      id_d        = '{inst: i_imem_rdata, pc: pc_q, pc4: pc_plus4, valid: 1'b1};

      case (state_q)
         IF_BOOT: begin
            state_d = IF_FETCH;
            if (i_redirect) begin
               pc_d     = redirect_tgt;
               id_flush = 1'b1;
            end
         end

         IF_FETCH: begin
            if (i_redirect) begin
               id_flush = 1'b1;
               if (i_imem_ack) begin
                  pc_d = redirect_tgt;
               end else begin
                  // The outstanding wrong-path request must still complete.
                  target_d = redirect_tgt;
                  state_d  = IF_DRAIN;
               end
            end else if (i_imem_ack) begin
               pc_d = pc_plus4;
               if (i_stall) begin
                  // Park the word so it issues after the stall without a refetch.
                  hold_inst_d = i_imem_rdata;
                  hold_pc_d   = pc_q;
                  state_d     = IF_HOLD;
               end else begin
                  id_load = 1'b1;
               end
            end else if (!i_stall) begin
               id_flush = 1'b1;
            end
         end

         IF_HOLD: begin
            if (i_redirect) begin
               pc_d     = redirect_tgt;
               id_flush = 1'b1;
               state_d  = IF_FETCH;
            end else if (!i_stall) begin
               id_d    = '{inst: hold_inst_q, pc: hold_pc_q, pc4: hold_pc_q + 32'd4, valid: 1'b1};
               id_load = 1'b1;
               state_d = IF_FETCH;
            end
         end

         IF_DRAIN: begin
            id_flush = 1'b1;
            if (i_redirect) begin
               target_d = redirect_tgt;
            end
            if (i_imem_ack) begin
               // A redirect arriving with the stale ack is the newest target.
               pc_d    = i_redirect ? redirect_tgt : target_q;
               state_d = IF_FETCH;
            end
         end

         default: begin
            state_d = IF_BOOT;
         end
      endcase
   end

   // NOTE: the hold buffer and saved target are reset too, even though they
   // are always written before use, so simulation never propagates X.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IF_BOOT;
         pc_q        <= RESET_PC;
         hold_inst_q <= NOP_INST;
         hold_pc_q   <= 32'h0;
         target_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
         target_q    <= target_d;
      end
   end

   if_id_reg u_if_id_reg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (id_load),
      .i_stall (i_stall),
      .i_flush (id_flush),
      .i_d     (id_d),
      .o_q     (id_q)
   );

   assign o_id_inst  = id_q.inst;
   assign o_id_pc    = id_q.pc;
   assign o_id_pc4   = id_q.pc4;
   assign o_id_valid = id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage. A memory model answers
// requests with a fixed or random latency; a program-order reference tracks
// which instruction decode should consume next and which address the next
// completed fetch must carry.
module tb_if_stage;
   import rv_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        i_clk, i_rst_n, i_stall, i_redirect, i_imem_ack;
   logic [31:0] i_redirect_pc, i_imem_rdata;
   logic        o_imem_req, o_id_valid;
   logic [31:0] o_imem_addr, o_id_inst, o_id_pc, o_id_pc4;

   int n_vec = 0;
   int n_err = 0;

   // memory model
   int lat_mode;   // negative: random latency 0..3 per request
   bit mem_busy;
   int mem_wait;

   // reference state
   logic [31:0] exp_pc, exp_fetch, pend_tgt, prev_addr;
   logic [31:0] prev_inst, prev_pc, prev_pc4;
   logic        prev_valid;
   bit          pend, prev_wait, prev_stall, prev_redirect;
   int          n_consumed = 0;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rdata  (i_imem_rdata),
      .o_id_inst     (o_id_inst),
      .o_id_pc       (o_id_pc),
      .o_id_pc4      (o_id_pc4),
      .o_id_valid    (o_id_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: observed %08h, expected %08h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address, distinct from the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      exp_pc        = RESET_PC;
      exp_fetch     = RESET_PC;
      pend          = 1'b0;
      pend_tgt      = 32'h0;
      prev_wait     = 1'b0;
      prev_stall    = 1'b0;
      prev_redirect = 1'b0;
      prev_addr     = 32'h0;
      prev_inst     = 32'h0;
      prev_pc       = 32'h0;
      prev_pc4      = 32'h0;
      prev_valid    = 1'b0;
      mem_busy      = 1'b0;
      mem_wait      = 0;
   endtask

   // Called just after a rising edge; asserts reset, checks the outputs at once.
   task automatic apply_reset(input string tag);
      i_rst_n    = 1'b0;
      i_stall    = 1'b0;
      i_redirect = 1'b0;
      i_imem_ack = 1'b0;
      #1;
      check({tag, "_req"},   o_imem_req,  32'd0);
      check({tag, "_addr"},  o_imem_addr, RESET_PC);
      check({tag, "_inst"},  o_id_inst,   NOP_INST);
      check({tag, "_pc"},    o_id_pc,     32'd0);
      check({tag, "_pc4"},   o_id_pc4,    32'd0);
      check({tag, "_valid"}, o_id_valid,  32'd0);
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   // Reference checks for one cycle, sampled at the falling edge.
   task automatic monitor();
      logic [31:0] tgt;
      tgt = {i_redirect_pc[31:2], 2'b00};

      check("addr_align", {30'd0, o_imem_addr[1:0]}, 32'd0);
      if (prev_wait) begin
         check("req_held",  o_imem_req,  32'd1);
         check("addr_held", o_imem_addr, prev_addr);
      end
      if (o_imem_req && i_imem_ack) begin
         check("fetch_addr", o_imem_addr, exp_fetch);
         exp_fetch = pend ? pend_tgt : o_imem_addr + 32'd4;
         pend      = 1'b0;
      end

      if (prev_redirect) begin
         check("flush_valid", o_id_valid, 32'd0);
      end else if (prev_stall) begin
         check("frozen_inst",  o_id_inst,  prev_inst);
         check("frozen_pc",    o_id_pc,    prev_pc);
         check("frozen_pc4",   o_id_pc4,   prev_pc4);
         check("frozen_valid", o_id_valid, prev_valid);
      end

      if (o_id_valid) begin
         check("id_inst", o_id_inst, mem_word(o_id_pc));
         check("id_pc4",  o_id_pc4,  o_id_pc + 32'd4);
      end else begin
         check("bubble_inst", o_id_inst, NOP_INST);
         check("bubble_pc",   o_id_pc,   32'd0);
         check("bubble_pc4",  o_id_pc4,  32'd0);
      end

      // Decode consumes the IF/ID instruction when neither stalled nor flushed.
      if (o_id_valid && !i_stall && !i_redirect) begin
         check("id_order", o_id_pc, exp_pc);
         exp_pc = o_id_pc + 32'd4;
         n_consumed++;
      end

      if (i_redirect) begin
         exp_pc = tgt;
         if (o_imem_req && !i_imem_ack) begin
            pend     = 1'b1;
            pend_tgt = tgt;
         end else begin
            exp_fetch = tgt;
         end
      end

      prev_wait     = o_imem_req && !i_imem_ack;
      prev_addr     = o_imem_addr;
      prev_stall    = i_stall;
      prev_redirect = i_redirect;
      prev_inst     = o_id_inst;
      prev_pc       = o_id_pc;
      prev_pc4      = o_id_pc4;
      prev_valid    = o_id_valid;
   endtask

   // One clock cycle: memory answers the request presented now, the monitor
   // samples at the falling edge, and control returns 1 time unit after the
   // next rising edge.
   task automatic step();
      if (o_imem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         end
         if (mem_wait == 0) begin
            i_imem_ack   = 1'b1;
            i_imem_rdata = mem_word(o_imem_addr);
            mem_busy     = 1'b0;
         end else begin
            i_imem_ack   = 1'b0;
            i_imem_rdata = $urandom;
            mem_wait--;
         end
      end else begin
         i_imem_ack   = 1'b0;
         i_imem_rdata = $urandom;
      end
      @(negedge i_clk);
      if (i_rst_n) monitor();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int gap, seen, guard, n0;
      i_rst_n       = 1'b1;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'h0;
      i_imem_ack    = 1'b0;
      i_imem_rdata  = 32'h0;
      lat_mode      = 0;
      model_reset();
      @(posedge i_clk);
      #1;

      // Zero-wait memory: one instruction per cycle from cycle 2.
      apply_reset("rst");
      check("c0_req",   o_imem_req, 32'd0);
      check("c0_valid", o_id_valid, 32'd0);
      step();
      check("c1_req",   o_imem_req,  32'd1);
      check("c1_addr",  o_imem_addr, RESET_PC);
      check("c1_valid", o_id_valid,  32'd0);
      for (int k = 0; k < 8; k++) begin
         step();
         check("stream_valid", o_id_valid, 32'd1);
         check("stream_pc",    o_id_pc,    RESET_PC + 32'(4 * k));
      end

      // Three wait cycles per request: exactly three bubbles between words.
      lat_mode = 3;
      gap  = 0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (o_id_valid) begin
            if (seen >= 1) check("lat3_gap", 32'(gap), 32'd3);
            seen++;
            gap = 0;
         end else begin
            gap++;
         end
      end
      check("lat3_count", {31'd0, seen >= 8}, 32'd1);

      // Stall for two cycles while the word at 0x10 is acknowledged.
      lat_mode = 0;
      apply_reset("rst2");
      guard = 0;
      while (!(o_imem_req && o_imem_addr == 32'h10) && guard < 20) begin
         step();
         guard++;
      end
      check("find_10", o_imem_addr, 32'h10);
      i_stall = 1'b1;
      check("stall_id0", o_id_pc, 32'h0C);
      step();
      check("stall_id1", o_id_pc,    32'h0C);
      check("stall_req", o_imem_req, 32'd0);
      step();
      i_stall = 1'b0;
      check("rel_id",    o_id_pc,    32'h0C);
      check("rel_valid", o_id_valid, 32'd1);
      step();
      check("held_pc",   o_id_pc,     32'h10);
      check("held_inst", o_id_inst,   mem_word(32'h10));
      check("next_req",  o_imem_req,  32'd1);
      check("next_addr", o_imem_addr, 32'h14);
      step();
      check("after_pc", o_id_pc, 32'h14);

      // Redirect to 0x200 while the request to 0x08 waits for its ack.
      apply_reset("rst3");
      lat_mode = 3;
      guard = 0;
      while (!(o_imem_req && o_imem_addr == 32'h08) && guard < 40) begin
         step();
         guard++;
      end
      check("find_08", o_imem_addr, 32'h08);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      check("drain_valid", o_id_valid,  32'd0);
      check("drain_req",   o_imem_req,  32'd1);
      check("drain_addr",  o_imem_addr, 32'h08);
      guard = 0;
      while (o_imem_addr == 32'h08 && guard < 10) begin
         step();
         check("drain_bubble", o_id_valid, 32'd0);
         guard++;
      end
      check("redir_req",  o_imem_req,  32'd1);
      check("redir_addr", o_imem_addr, 32'h200);
      guard = 0;
      while (!o_id_valid && guard < 10) begin
         step();
         guard++;
      end
      check("redir_first_pc", o_id_pc, 32'h200);

      // Redirect and stall together: the flush wins, target is word-aligned.
      lat_mode = 0;
      repeat (4) step();
      i_stall       = 1'b1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h103;
      step();
      i_stall    = 1'b0;
      i_redirect = 1'b0;
      check("rs_valid", o_id_valid,  32'd0);
      check("rs_req",   o_imem_req,  32'd1);
      check("rs_addr",  o_imem_addr, 32'h100);
      step();
      check("rs_id_pc",    o_id_pc,    32'h100);
      check("rs_id_valid", o_id_valid, 32'd1);

      // Reset while draining a wrong-path request.
      lat_mode = 3;
      guard = 0;
      while (!(o_imem_req && !mem_busy) && guard < 10) begin
         step();
         guard++;
      end
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h300;
      step();
      i_redirect = 1'b0;
      step();
      check("pre_rst_req", o_imem_req, 32'd1);
      apply_reset("mid_drain");
      lat_mode = 0;
      check("md_c0_req", o_imem_req, 32'd0);
      step();
      check("md_c1_req",  o_imem_req,  32'd1);
      check("md_c1_addr", o_imem_addr, RESET_PC);
      step();
      check("md_c2_pc",    o_id_pc,    RESET_PC);
      check("md_c2_valid", o_id_valid, 32'd1);

      // Random latency, stalls and redirects (some near the top of memory).
      apply_reset("rnd");
      lat_mode = -1;
      n0 = n_consumed;
      for (int k = 0; k < 3000; k++) begin
         i_stall    = ($urandom_range(0, 3) == 0);
         i_redirect = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0)
            i_redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else
            i_redirect_pc = $urandom;
         step();
      end
      i_stall    = 1'b0;
      i_redirect = 1'b0;
      check("rnd_progress", {31'd0, (n_consumed - n0) >= 300}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
